// File: rtl/right_shifter.sv
// Registered log2 barrel right-shifter, logical or arithmetic fill; 1-cycle latency.
// Accepts one operand per cycle with no backpressure; out_valid follows in_valid by one edge.
module right_shifter #(
  parameter int WIDTH = 8,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] data_in,
  input  logic [SHW-1:0]   shift,
  input  logic             mode,
  output logic             out_valid,
  output logic [WIDTH-1:0] data_out
);

  logic             fill;
  logic [WIDTH-1:0] stage [0:SHW];
  logic [WIDTH-1:0] shifted;

  // Sign fill only in arithmetic mode; the operand MSB is reused by every stage.
  assign fill     = mode & data_in[WIDTH-1];
  assign stage[0] = data_in;

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    localparam int SH = 1 << k;
    assign stage[k+1] = shift[k] ? {{SH{fill}}, stage[k][WIDTH-1:SH]} : stage[k];
  end

  assign shifted = stage[SHW];

  // data_out only moves on accepted operands so it holds steady while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        data_out <= shifted;
      end
    end
  end

endmodule

// File: tb/tb_right_shifter.sv
// Self-checking bench for right_shifter (WIDTH=8) against a plain >> / >>> reference.
module tb_right_shifter;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] data_in;
  logic [2:0] shift;
  logic       mode;
  logic       out_valid;
  logic [7:0] data_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  right_shifter #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .data_in  (data_in),
    .shift    (shift),
    .mode     (mode),
    .out_valid(out_valid),
    .data_out (data_out)
  );

  function automatic logic [7:0] model_shift(input logic [7:0] d, input logic [2:0] s,
                                             input logic m);
    logic signed [7:0] sd;
    logic [7:0]        r;
    if (m) begin
      sd = d;
      sd = sd >>> s;
      r  = sd;
    end else begin
      r = d >> s;
    end
    return r;
  endfunction

  // Apply inputs, take one rising edge, then settle 1 time unit before sampling.
  task automatic drive(input logic v, input logic [7:0] d, input logic [2:0] s,
                       input logic m, input logic r);
    in_valid = v;
    data_in  = d;
    shift    = s;
    mode     = m;
    rst      = r;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 8'hFF, 3'd3, 1'b1, 1'b1);
      n_tests++;
      if (data_out !== 8'h00 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset[%0d]: data_out=%h out_valid=%b, expected 00/0", i, data_out, out_valid);
      end
    end
  endtask

  task automatic test_logical_sweep();
    logic [7:0] exp_tab [8] = '{8'hAA, 8'h55, 8'h2A, 8'h15, 8'h0A, 8'h05, 8'h02, 8'h01};
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 8'hAA, 3'(i), 1'b0, 1'b0);
      n_tests++;
      if (data_out !== exp_tab[i] || out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL logical_aa shift=%0d: data_out=%h out_valid=%b, expected %h/1",
                 i, data_out, out_valid, exp_tab[i]);
      end
    end
  endtask

  task automatic test_arith_sweep();
    logic [7:0] exp_tab [8] = '{8'hAA, 8'hD5, 8'hEA, 8'hF5, 8'hFA, 8'hFD, 8'hFE, 8'hFF};
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 8'hAA, 3'(i), 1'b1, 1'b0);
      n_tests++;
      if (data_out !== exp_tab[i] || out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL arith_aa shift=%0d: data_out=%h out_valid=%b, expected %h/1",
                 i, data_out, out_valid, exp_tab[i]);
      end
    end
  endtask

  task automatic test_positive_and_idle();
    drive(1'b1, 8'h6A, 3'd2, 1'b1, 1'b0);
    n_tests++;
    if (data_out !== 8'h1A || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL positive_arith: data_out=%h out_valid=%b, expected 1a/1", data_out, out_valid);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'($urandom), 3'($urandom), 1'($urandom), 1'b0);
      n_tests++;
      if (data_out !== 8'h1A || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_hold[%0d]: data_out=%h out_valid=%b, expected 1a/0", i, data_out, out_valid);
      end
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 8'h80, 3'd7, 1'b0, 1'b0);
    n_tests++;
    if (data_out !== 8'h01 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_first: data_out=%h out_valid=%b, expected 01/1", data_out, out_valid);
    end
    drive(1'b1, 8'h80, 3'd7, 1'b1, 1'b0);
    n_tests++;
    if (data_out !== 8'hFF || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_second: data_out=%h out_valid=%b, expected ff/1", data_out, out_valid);
    end
  endtask

  task automatic test_reset_collision();
    drive(1'b1, 8'hAA, 3'd1, 1'b0, 1'b0);
    n_tests++;
    if (data_out !== 8'h55 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_collision: data_out=%h out_valid=%b, expected 55/1", data_out, out_valid);
    end
    drive(1'b1, 8'hF0, 3'd1, 1'b1, 1'b1);
    n_tests++;
    if (data_out !== 8'h00 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_collision: data_out=%h out_valid=%b, expected 00/0", data_out, out_valid);
    end
    drive(1'b0, 8'hF0, 3'd1, 1'b1, 1'b0);
    n_tests++;
    if (data_out !== 8'h00 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL post_rst_idle: data_out=%h out_valid=%b, expected 00/0", data_out, out_valid);
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_d;
    logic       exp_v;
    logic       v, m;
    logic [7:0] d;
    logic [2:0] s;
    exp_d = data_out === 8'h00 ? 8'h00 : 8'hxx;  // entered straight after a reset
    exp_d = 8'h00;
    for (int i = 0; i < 300; i++) begin
      v = ($urandom_range(0, 3) != 0);
      d = 8'($urandom);
      s = 3'($urandom);
      m = 1'($urandom);
      if (v) exp_d = model_shift(d, s, m);
      exp_v = v;
      drive(v, d, s, m, 1'b0);
      n_tests++;
      if (data_out !== exp_d || out_valid !== exp_v) begin
        n_fail++;
        $display("FAIL random[%0d] d=%h s=%0d m=%b v=%b: data_out=%h out_valid=%b, expected %h/%b",
                 i, d, s, m, v, data_out, out_valid, exp_d, exp_v);
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    data_in  = 8'h00;
    shift    = 3'd0;
    mode     = 1'b0;
    test_reset();
    test_logical_sweep();
    test_arith_sweep();
    test_positive_and_idle();
    test_back_to_back();
    test_reset_collision();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
